// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and a local read port.
// Optional 3-sample majority glitch filter on SCL/SDA is enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_target_regfile #(
   parameter logic [6:0]  TGT_ADDR = 7'h50,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          sda_oe,
   input  logic [AW-1:0] loc_addr,
   output logic [7:0]    loc_rdata,
   output logic          wr_stb,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy,
   output logic          done,
   output logic          ack_err
);

   typedef enum logic [3:0] {
      StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck, StWait
   } state_e;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_s, sda_s, scl_h_q, sda_h_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
         scl_h_q    <= scl_s;
         sda_h_q    <= sda_s;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [1:0] scl_p_q, sda_p_q;
   logic       scl_f_q, sda_f_q;

   // Majority of the current and two previous samples, registered: single-clk pulses vanish.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scl_p_q <= 2'b11;
         sda_p_q <= 2'b11;
         scl_f_q <= 1'b1;
         sda_f_q <= 1'b1;
      end else begin
         scl_p_q <= {scl_p_q[0], scl_sync_q[1]};
         sda_p_q <= {sda_p_q[0], sda_sync_q[1]};
         scl_f_q <= (scl_sync_q[1] & scl_p_q[0]) | (scl_sync_q[1] & scl_p_q[1]) |
                    (scl_p_q[0] & scl_p_q[1]);
         sda_f_q <= (sda_sync_q[1] & sda_p_q[0]) | (sda_sync_q[1] & sda_p_q[1]) |
                    (sda_p_q[0] & sda_p_q[1]);
      end
   end

   assign scl_s = scl_f_q;
   assign sda_s = sda_f_q;
`else
   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];
`endif

   logic scl_rise, scl_fall, start_det, stop_det;
   assign scl_rise  = scl_s & ~scl_h_q;
   assign scl_fall  = ~scl_s & scl_h_q;
   assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
   assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [7:0]    sh_q, sh_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          rw_q, rw_d;
   logic          ph_q, ph_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          stb_q, stb_d;
   logic [AW-1:0] wa_q, wa_d;
   logic [7:0]    wd_q, wd_d;
   logic [7:0]    rx_byte;
   logic [7:0]    regs_q [DEPTH];

   assign rx_byte = {sh_q[6:0], sda_s};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      rw_d    = rw_q;
      ph_d    = ph_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      stb_d   = 1'b0;
      wa_d    = wa_q;
      wd_d    = wd_q;
      if (stop_det) begin
         state_d = StIdle;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = busy_q;
      end else if (start_det) begin
         state_d = StAddr;
         cnt_d   = 3'd0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StAddr, StPtr, StWdata: begin
               if (scl_rise) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     ph_d = 1'b0;
                     if (state_q == StAddr) begin
                        if (rx_byte[7:1] == TGT_ADDR) begin
                           state_d = StAddrAck;
                           busy_d  = 1'b1;
                           rw_d    = rx_byte[0];
                        end else begin
                           state_d = StWait;
                        end
                     end else if (state_q == StPtr) begin
                        state_d = StPtrAck;
                        ptr_d   = rx_byte[AW-1:0];
                     end else begin
                        state_d = StWdataAck;
                        stb_d   = 1'b1;
                        wa_d    = ptr_q;
                        wd_d    = rx_byte;
                     end
                  end
               end
            end
            StAddrAck, StPtrAck, StWdataAck: begin
               // First fall drives the ACK, second fall ends the ACK slot.
               if (scl_fall) begin
                  if (!ph_q) begin
                     oe_d = 1'b1;
                     ph_d = 1'b1;
                  end else begin
                     oe_d  = 1'b0;
                     cnt_d = 3'd0;
                     if (state_q == StAddrAck && rw_q) begin
                        state_d = StRdata;
                        sh_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                     end else if (state_q == StAddrAck) begin
                        state_d = StPtr;
                     end else begin
                        state_d = StWdata;
                        if (state_q == StWdataAck) ptr_d = ptr_q + AW'(1);
                     end
                  end
               end
            end
            StRdata: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     oe_d    = 1'b0;
                     state_d = StRdataAck;
                     ph_d    = 1'b0;
                  end else begin
                     oe_d  = ~sh_q[6];
                     sh_d  = {sh_q[6:0], 1'b0};
                     cnt_d = cnt_q + 3'd1;
                  end
               end
            end
            StRdataAck: begin
               if (scl_rise && !ph_q) begin
                  if (!sda_s) begin
                     ptr_d = ptr_q + AW'(1);
                     ph_d  = 1'b1;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StWait;
                  end
               end else if (scl_fall && ph_q) begin
                  state_d = StRdata;
                  cnt_d   = 3'd0;
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
               end
            end
            StWait: oe_d = 1'b0;
            default: begin
               state_d = StIdle;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         sh_q    <= 8'h00;
         ptr_q   <= '0;
         rw_q    <= 1'b0;
         ph_q    <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         stb_q   <= 1'b0;
         wa_q    <= '0;
         wd_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ptr_q   <= ptr_d;
         rw_q    <= rw_d;
         ph_q    <= ph_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         stb_q   <= stb_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= 8'h00;
      end else if (stb_d) begin
         regs_q[wa_d] <= wd_d;
      end
   end

   // Reset releases SDA immediately rather than at the next edge.
   assign sda_oe    = oe_q & rst;
   assign loc_rdata = regs_q[loc_addr];
   assign wr_stb    = stb_q;
   assign wr_addr   = wa_q;
   assign wr_data   = wd_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign ack_err   = err_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bus-level master tasks plus pulse monitors on the outputs.
module tb_i2c_target_regfile;

   localparam int AW = 4;
   localparam int Q  = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          scl_m, sda_m;
   logic          sda_oe;
   logic          sda_line;
   logic [AW-1:0] loc_addr;
   logic [7:0]    loc_rdata;
   logic          wr_stb;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy, done, ack_err;

   int n_checks = 0;
   int n_fail   = 0;

   int stb_cnt = 0, done_cnt = 0, err_cnt = 0, oe_cnt = 0, busy_cnt = 0;
   logic [AW-1:0] stb_a [64];
   logic [7:0]    stb_d [64];

   always #5 clk = ~clk;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_regfile #(
      .TGT_ADDR (7'h50),
      .DEPTH    (16),
      .AW       (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_in    (scl_m),
      .sda_in    (sda_line),
      .sda_oe    (sda_oe),
      .loc_addr  (loc_addr),
      .loc_rdata (loc_rdata),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .ack_err   (ack_err)
   );

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_a[stb_cnt % 64] = wr_addr;
         stb_d[stb_cnt % 64] = wr_data;
         stb_cnt++;
      end
      if (done) done_cnt++;
      if (ack_err) err_cnt++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_rstart();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      scl_m = 1'b0; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic send_bit(input logic b, output logic s);
      sda_m = b; wq();
      scl_m = 1'b1; wq();
      s = sda_line; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(b[i], s);
      send_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         send_bit(1'b1, s);
         b[i] = s;
      end
      send_bit(nack, s);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if ({sda_oe, busy, done, wr_stb, ack_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 00000", {sda_oe, busy, done, wr_stb, ack_err});
      end
      n_checks++;
      if (wr_addr !== 4'd0 || wr_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_wr: got addr %0d data %h want 0 00", wr_addr, wr_data);
      end
      loc_addr = 4'd7; #1;
      n_checks++;
      if (loc_rdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_reg7: got %h want 00", loc_rdata);
      end
      rst = 1'b1;
      wq();
   endtask

   task automatic test_write();
      logic [3:0] acks;
      int s0, d0;
      s0 = stb_cnt; d0 = done_cnt;
      i2c_start();
      write_byte(8'hA0, acks[3]);
      write_byte(8'h03, acks[2]);
      write_byte(8'h5A, acks[1]);
      write_byte(8'hC3, acks[0]);
      i2c_stop();
      wq();
      n_checks++;
      if (acks !== 4'b1111) begin n_fail++; $display("FAIL write_acks: got %b want 1111", acks); end
      n_checks++;
      if (stb_cnt - s0 != 2) begin
         n_fail++; $display("FAIL write_stb_count: got %0d want 2", stb_cnt - s0);
      end
      n_checks++;
      if (stb_a[s0 % 64] !== 4'd3 || stb_d[s0 % 64] !== 8'h5A) begin
         n_fail++;
         $display("FAIL write_stb0: got (%0d,%h) want (3,5a)", stb_a[s0 % 64], stb_d[s0 % 64]);
      end
      n_checks++;
      if (stb_a[(s0 + 1) % 64] !== 4'd4 || stb_d[(s0 + 1) % 64] !== 8'hC3) begin
         n_fail++;
         $display("FAIL write_stb1: got (%0d,%h) want (4,c3)", stb_a[(s0 + 1) % 64],
                  stb_d[(s0 + 1) % 64]);
      end
      loc_addr = 4'd4; #1;
      n_checks++;
      if (loc_rdata !== 8'hC3) begin n_fail++; $display("FAIL write_reg4: got %h want c3", loc_rdata); end
      n_checks++;
      if (done_cnt - d0 != 1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL write_done: got done %0d busy %b want 1 0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] b0, b1;
      int e0, s0;
      e0 = err_cnt; s0 = stb_cnt;
      i2c_start();
      write_byte(8'hA0, a0);
      write_byte(8'h03, a1);
      i2c_rstart();
      write_byte(8'hA1, a2);
      read_byte(1'b0, b0);
      read_byte(1'b1, b1);
      i2c_stop();
      wq();
      n_checks++;
      if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL read_acks: got %b want 111", {a0, a1, a2}); end
      n_checks++;
      if (b0 !== 8'h5A) begin n_fail++; $display("FAIL read_byte0: got %h want 5a", b0); end
      n_checks++;
      if (b1 !== 8'hC3) begin n_fail++; $display("FAIL read_byte1: got %h want c3", b1); end
      n_checks++;
      if (err_cnt - e0 != 1 || stb_cnt != s0) begin
         n_fail++;
         $display("FAIL read_err: got ack_err %0d stb %0d want 1 0", err_cnt - e0, stb_cnt - s0);
      end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int o0, b0, s0, d0;
      o0 = oe_cnt; b0 = busy_cnt; s0 = stb_cnt; d0 = done_cnt;
      i2c_start();
      write_byte(8'hA2, a0);
      write_byte(8'h55, a1);
      i2c_stop();
      wq();
      n_checks++;
      if (a0 !== 1'b0 || oe_cnt != o0) begin
         n_fail++; $display("FAIL mismatch_oe: got ack %b oe cycles %0d want 0 0", a0, oe_cnt - o0);
      end
      n_checks++;
      if (busy_cnt != b0 || stb_cnt != s0 || done_cnt != d0) begin
         n_fail++;
         $display("FAIL mismatch_quiet: got busy %0d stb %0d done %0d want 0 0 0",
                  busy_cnt - b0, stb_cnt - s0, done_cnt - d0);
      end
   endtask

   task automatic test_wrap();
      logic a;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h0F, a);
      write_byte(8'h11, a);
      write_byte(8'h22, a);
      i2c_stop();
      loc_addr = 4'd15; #1;
      n_checks++;
      if (loc_rdata !== 8'h11) begin n_fail++; $display("FAIL wrap_reg15: got %h want 11", loc_rdata); end
      loc_addr = 4'd0; #1;
      n_checks++;
      if (loc_rdata !== 8'h22) begin n_fail++; $display("FAIL wrap_reg0: got %h want 22", loc_rdata); end
   endtask

   task automatic test_abort();
      logic a, s;
      int s0, d0;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h05, a);
      s0 = stb_cnt; d0 = done_cnt;
      send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
      i2c_stop();
      wq();
      loc_addr = 4'd5; #1;
      n_checks++;
      if (stb_cnt != s0 || loc_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL abort_nowrite: got stb %0d reg5 %h want 0 00", stb_cnt - s0, loc_rdata);
      end
      n_checks++;
      if (busy !== 1'b0 || done_cnt - d0 != 1) begin
         n_fail++; $display("FAIL abort_idle: got busy %b done %0d want 0 1", busy, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid_read();
      logic a;
      i2c_start();
      write_byte(8'hA0, a);
      write_byte(8'h03, a);
      i2c_rstart();
      write_byte(8'hA1, a);
      // reg3 = 0x5A, MSB 0: target is now pulling SDA low.
      n_checks++;
      if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstread_drive: got %b want 1", sda_oe); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (sda_oe !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rstread_release: got oe %b busy %b want 0 0", sda_oe, busy);
      end
      loc_addr = 4'd3; #1;
      n_checks++;
      if (loc_rdata !== 8'h00) begin n_fail++; $display("FAIL rstread_reg3: got %h want 00", loc_rdata); end
      loc_addr = 4'd15; #1;
      n_checks++;
      if (loc_rdata !== 8'h00) begin n_fail++; $display("FAIL rstread_reg15: got %h want 00", loc_rdata); end
      @(negedge clk);
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      rst = 1'b1; wq();
   endtask

   task automatic test_glitch();
      logic a;
      int d0;
      i2c_start();
      write_byte(8'hA0, a);
      d0 = done_cnt;
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; @(negedge clk);
      sda_m = 1'b1; wq();
`ifdef I2C_GLITCH_FILTER_EN
      n_checks++;
      if (busy !== 1'b1 || done_cnt != d0) begin
         n_fail++; $display("FAIL glitch_filtered: got busy %b done %0d want 1 0", busy, done_cnt - d0);
      end
`else
      // Unfiltered, the pulse reads as START followed by STOP, ending the transaction.
      n_checks++;
      if (busy !== 1'b0 || done_cnt - d0 != 1) begin
         n_fail++; $display("FAIL glitch_unfiltered: got busy %b done %0d want 0 1", busy, done_cnt - d0);
      end
`endif
      i2c_stop();
      wq();
   endtask

   initial begin
      rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; loc_addr = '0;
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_wrap();
      test_abort();
      test_reset_mid_read();
      test_glitch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
